req_encoder: RTL

Sequential request encoder: the inverse of the team's one-hot decoders. It collects request pulses on an N-bit vector into a pending register and issues them one at a time as binary codes over a valid/ready handshake. Priority is lowest-index-first, or optionally round-robin. It sits between interrupt or event sources and any consumer that re-expands codes through the existing 3/6/7-bit decoders.

---
 rtl/req_encoder_pkg.sv | 24 ++
 rtl/req_encoder_prio_pick.sv | 42 ++++
 rtl/req_encoder.sv | 115 +++++++++++
 3 files changed

// File: rtl/req_encoder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | req_encoder_pkg : shared FSM encodings and width helper          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package req_encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Also used for the 3/6/7-bit decoder widths elsewhere in the codebase.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/req_encoder_prio_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prio_pick : lowest-set-bit search starting at a rotating pointer |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module prio_pick
    import req_encoder_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    // Doubled vector: bit start+i of {vec,vec} is vec[(start+i) mod N].
    logic [2*N-2:0] w_dbl;
    logic [N-1:0]   w_rot;
    int             w_pos;
    int             w_sum;

    assign w_dbl = {vec[N-2:0], vec};
    assign found = |vec;

    always_comb begin
        w_rot = '0;
        w_pos = 0;
        for (int i = 0; i < N; i++) begin
            w_rot[i] = w_dbl[i + int'(start)];
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) w_pos = i;
        end
        w_sum = int'(start) + w_pos;
        if (w_sum >= N) w_sum = w_sum - N;
        idx = W'(w_sum);
    end

endmodule
`default_nettype wire

// File: rtl/req_encoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | req_encoder : pending-request collector issuing binary codes     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module req_encoder
    import req_encoder_pkg::*;
#(
    parameter int N           = 8,
    parameter int W           = clog2(N),
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         clr,
    output logic         code_valid,
    input  logic         code_ready,
    output logic [W-1:0] code,
    output logic [N-1:0] pending,
    output logic         dup
);

    state_t       r_state;
    state_t       w_state_next;
    logic [N-1:0] r_pending;
    logic [N-1:0] w_pending_next;
    logic [N-1:0] w_issue_mask;
    logic [W-1:0] r_code;
    logic [W-1:0] w_start;
    logic [W-1:0] w_pick_idx;
    logic         w_pick_found;
    logic         w_load;
    logic         w_dup_set;
    logic         r_dup;

    prio_pick #(.N(N), .W(W)) u_pick (
        .vec   (r_pending),
        .start (w_start),
        .found (w_pick_found),
        .idx   (w_pick_idx)
    );

    generate
        if (ROUND_ROBIN) begin : g_rr
            logic [W-1:0] r_ptr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr <= '0;
                end else if (clr) begin
                    r_ptr <= '0;
                end else if (w_load) begin
                    r_ptr <= (w_pick_idx == W'(N - 1)) ? '0 : w_pick_idx + 1'b1;
                end
            end
            assign w_start = r_ptr;
        end else begin : g_fixed
            assign w_start = '0;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_load       = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (code_ready) begin
                    if (w_pick_found) w_load = 1'b1;
                    else              w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (clr) begin
            w_state_next = IDLE;
            w_load       = 1'b0;
        end
    end

    // Issued line clears, but a same-cycle request re-arms it without counting as a duplicate.
    assign w_issue_mask   = w_load ? (N'(1) << w_pick_idx) : '0;
    assign w_pending_next = (r_pending & ~w_issue_mask) | req;
    assign w_dup_set      = |(req & r_pending & ~w_issue_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_code    <= '0;
            r_dup     <= 1'b0;
        end else if (clr) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_dup     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            if (w_dup_set) r_dup  <= 1'b1;
            if (w_load)    r_code <= w_pick_idx;
        end
    end

    assign code_valid = (r_state == HOLD);
    assign code       = r_code;
    assign pending    = r_pending;
    assign dup        = r_dup;

endmodule
`default_nettype wire
